// File: rtl/execute_stage_if.sv
// ID/EX-to-EX/MEM signal bundle for execute_stage. The slave side is the execute stage and
// the master side is the pipeline around it.
interface execute_stage_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  i_stall;
    logic                  i_flush;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic [ADDR_WIDTH-1:0] i_pc_plus4;
    logic [DATA_WIDTH-1:0] i_rs1_data;
    logic [DATA_WIDTH-1:0] i_rs2_data;
    logic [DATA_WIDTH-1:0] i_imm_ext;
    logic                  i_alu_src;
    logic [3:0]            i_alu_op;
    logic                  i_md_start;
    logic [REG_ADDR_W-1:0] i_rd_addr;
    logic [2:0]            i_result_src;
    logic                  i_mem_we;
    logic                  i_reg_we;
    logic [2:0]            i_func3;
    logic [1:0]            i_forward_src;

    logic                  o_busy;
    logic [ADDR_WIDTH-1:0] o_pc_plus4;
    logic [ADDR_WIDTH-1:0] o_pc_target;
    logic [DATA_WIDTH-1:0] o_alu_result;
    logic [DATA_WIDTH-1:0] o_write_data;
    logic [DATA_WIDTH-1:0] o_imm_ext;
    logic [REG_ADDR_W-1:0] o_rd_addr;
    logic [2:0]            o_result_src;
    logic                  o_mem_we;
    logic                  o_reg_we;
    logic [2:0]            o_func3;
    logic [1:0]            o_forward_src;

    modport master (
        output i_stall, i_flush, i_pc, i_pc_plus4, i_rs1_data, i_rs2_data, i_imm_ext,
               i_alu_src, i_alu_op, i_md_start, i_rd_addr, i_result_src, i_mem_we,
               i_reg_we, i_func3, i_forward_src,
        input  o_busy, o_pc_plus4, o_pc_target, o_alu_result, o_write_data, o_imm_ext,
               o_rd_addr, o_result_src, o_mem_we, o_reg_we, o_func3, o_forward_src
    );

    modport slave (
        input  i_stall, i_flush, i_pc, i_pc_plus4, i_rs1_data, i_rs2_data, i_imm_ext,
               i_alu_src, i_alu_op, i_md_start, i_rd_addr, i_result_src, i_mem_we,
               i_reg_we, i_func3, i_forward_src,
        output o_busy, o_pc_plus4, o_pc_target, o_alu_result, o_write_data, o_imm_ext,
               o_rd_addr, o_result_src, o_mem_we, o_reg_we, o_func3, o_forward_src
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch target, iterative MUL/DIV and the EX/MEM register.
// Define EXEC_MULH_EN to add MULH/MULHSU/MULHU (2*DW accumulator); otherwise they return 0.
module execute_stage #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic            i_clk,
    input  logic            i_arst,
    execute_stage_if.slave  io_ex
);
    localparam int DW  = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = $clog2(DATA_WIDTH);
`ifdef EXEC_MULH_EN
    localparam int MW  = 2 * DATA_WIDTH;
`else
    localparam int MW  = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    md_state_t             r_state;
    logic [CW-1:0]         r_count;
    logic [2:0]            r_func3;
    logic [MW-1:0]         r_mcand;
    logic [MW-1:0]         r_acc;
    logic [DW-1:0]         r_mplier;
    logic [DW-1:0]         r_quo;
    logic [DW-1:0]         r_rem;
    logic [DW-1:0]         r_divisor;
    logic [DW-1:0]         r_dividend;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_div_zero;

    logic [ADDR_WIDTH-1:0] r_pc_plus4;
    logic [ADDR_WIDTH-1:0] r_pc_target;
    logic [DW-1:0]         r_alu_result;
    logic [DW-1:0]         r_write_data;
    logic [DW-1:0]         r_imm_ext;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [2:0]            r_result_src;
    logic                  r_mem_we;
    logic                  r_reg_we;
    logic [2:0]            r_func3_q;
    logic [1:0]            r_forward_src;

    logic [DW-1:0]         w_op_b;
    logic [SHW-1:0]        w_shamt;
    logic [DW-1:0]         w_alu_result;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DW-1:0]         w_abs_a;
    logic [DW-1:0]         w_abs_b;
    logic [DW:0]           w_rem_shift;
    logic [DW:0]           w_rem_diff;
    logic [DW-1:0]         w_quo_signed;
    logic [DW-1:0]         w_rem_signed;
    logic [DW-1:0]         w_md_result;
    logic                  w_busy;
    logic                  w_bubble;
`ifdef EXEC_MULH_EN
    logic [MW-1:0]         w_prod;
    assign w_prod = r_neg_q ? -r_acc : r_acc;
`endif

    // ALU: operand select and opcode decode
    always_comb begin
        w_op_b  = io_ex.i_alu_src ? io_ex.i_imm_ext : io_ex.i_rs2_data;
        w_shamt = w_op_b[SHW-1:0];
        case (io_ex.i_alu_op)
            4'd0:    w_alu_result = io_ex.i_rs1_data + w_op_b;
            4'd1:    w_alu_result = io_ex.i_rs1_data - w_op_b;
            4'd2:    w_alu_result = io_ex.i_rs1_data & w_op_b;
            4'd3:    w_alu_result = io_ex.i_rs1_data | w_op_b;
            4'd4:    w_alu_result = io_ex.i_rs1_data ^ w_op_b;
            4'd5:    w_alu_result = io_ex.i_rs1_data << w_shamt;
            4'd6:    w_alu_result = io_ex.i_rs1_data >> w_shamt;
            4'd7:    w_alu_result = $signed(io_ex.i_rs1_data) >>> w_shamt;
            4'd8:    w_alu_result = {{(DW-1){1'b0}}, ($signed(io_ex.i_rs1_data) < $signed(w_op_b))};
            4'd9:    w_alu_result = {{(DW-1){1'b0}}, (io_ex.i_rs1_data < w_op_b)};
            default: w_alu_result = {DW{1'b0}};
        endcase
    end

    // Operand signs: signed ops iterate on magnitudes and fix the sign in DONE
    always_comb begin
        case (io_ex.i_func3)
            3'd4, 3'd6: begin
                w_a_neg = io_ex.i_rs1_data[DW-1];
                w_b_neg = io_ex.i_rs2_data[DW-1];
            end
`ifdef EXEC_MULH_EN
            3'd1: begin
                w_a_neg = io_ex.i_rs1_data[DW-1];
                w_b_neg = io_ex.i_rs2_data[DW-1];
            end
            3'd2: begin
                w_a_neg = io_ex.i_rs1_data[DW-1];
                w_b_neg = 1'b0;
            end
`endif
            default: begin
                w_a_neg = 1'b0;
                w_b_neg = 1'b0;
            end
        endcase
        w_abs_a = w_a_neg ? -io_ex.i_rs1_data : io_ex.i_rs1_data;
        w_abs_b = w_b_neg ? -io_ex.i_rs2_data : io_ex.i_rs2_data;
    end

    // One restoring-division step; a non-negative difference sets the quotient bit
    always_comb begin
        w_rem_shift = {r_rem, r_quo[DW-1]};
        w_rem_diff  = w_rem_shift - {1'b0, r_divisor};
    end

    // Final MUL/DIV result with sign fix-up and divide-by-zero override
    always_comb begin
        w_quo_signed = r_neg_q ? -r_quo : r_quo;
        w_rem_signed = r_neg_r ? -r_rem : r_rem;
        case (r_func3)
            3'd0:       w_md_result = r_acc[DW-1:0];
`ifdef EXEC_MULH_EN
            3'd1, 3'd2, 3'd3: w_md_result = w_prod[MW-1:DW];
`else
            3'd1, 3'd2, 3'd3: w_md_result = {DW{1'b0}};
`endif
            3'd4, 3'd5: w_md_result = r_div_zero ? {DW{1'b1}} : w_quo_signed;
            3'd6, 3'd7: w_md_result = r_div_zero ? r_dividend : w_rem_signed;
            default:    w_md_result = {DW{1'b0}};
        endcase
    end

    assign w_busy   = ((r_state == S_IDLE) && io_ex.i_md_start && !io_ex.i_flush) ||
                      (r_state == S_BUSY);
    assign w_bubble = io_ex.i_flush || (!io_ex.i_stall && w_busy);

    // MUL/DIV sequencer and datapath
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state    <= S_IDLE;
            r_count    <= {CW{1'b0}};
            r_func3    <= 3'd0;
            r_mcand    <= {MW{1'b0}};
            r_acc      <= {MW{1'b0}};
            r_mplier   <= {DW{1'b0}};
            r_quo      <= {DW{1'b0}};
            r_rem      <= {DW{1'b0}};
            r_divisor  <= {DW{1'b0}};
            r_dividend <= {DW{1'b0}};
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (io_ex.i_flush) begin
            r_state <= S_IDLE;
            r_count <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_ex.i_md_start) begin
                        r_state    <= S_BUSY;
                        r_count    <= CW'(DW - 1);
                        r_func3    <= io_ex.i_func3;
                        r_mcand    <= MW'(w_abs_a);
                        r_acc      <= {MW{1'b0}};
                        r_mplier   <= w_abs_b;
                        r_quo      <= w_abs_a;
                        r_rem      <= {DW{1'b0}};
                        r_divisor  <= w_abs_b;
                        r_dividend <= io_ex.i_rs1_data;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= (io_ex.i_rs2_data == {DW{1'b0}});
                    end
                end
                S_BUSY: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : {MW{1'b0}});
                    r_mcand  <= {r_mcand[MW-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[DW-1:1]};
                    if (!w_rem_diff[DW]) begin
                        r_rem <= w_rem_diff[DW-1:0];
                        r_quo <= {r_quo[DW-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_shift[DW-1:0];
                        r_quo <= {r_quo[DW-2:0], 1'b0};
                    end
                    if (r_count == {CW{1'b0}}) begin
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    if (!io_ex.i_stall) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM register: flush beats stall, stall holds, busy inserts a bubble
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst || w_bubble) begin
            r_pc_plus4    <= {ADDR_WIDTH{1'b0}};
            r_pc_target   <= {ADDR_WIDTH{1'b0}};
            r_alu_result  <= {DW{1'b0}};
            r_write_data  <= {DW{1'b0}};
            r_imm_ext     <= {DW{1'b0}};
            r_rd_addr     <= {REG_ADDR_W{1'b0}};
            r_result_src  <= 3'd0;
            r_mem_we      <= 1'b0;
            r_reg_we      <= 1'b0;
            r_func3_q     <= 3'd0;
            r_forward_src <= 2'd0;
        end else if (!io_ex.i_stall) begin
            r_pc_plus4    <= io_ex.i_pc_plus4;
            r_pc_target   <= io_ex.i_pc + io_ex.i_imm_ext[ADDR_WIDTH-1:0];
            r_alu_result  <= (r_state == S_DONE) ? w_md_result : w_alu_result;
            r_write_data  <= io_ex.i_rs2_data;
            r_imm_ext     <= io_ex.i_imm_ext;
            r_rd_addr     <= io_ex.i_rd_addr;
            r_result_src  <= io_ex.i_result_src;
            r_mem_we      <= io_ex.i_mem_we;
            r_reg_we      <= io_ex.i_reg_we;
            r_func3_q     <= io_ex.i_func3;
            r_forward_src <= io_ex.i_forward_src;
        end
    end

    assign io_ex.o_busy        = w_busy;
    assign io_ex.o_pc_plus4    = r_pc_plus4;
    assign io_ex.o_pc_target   = r_pc_target;
    assign io_ex.o_alu_result  = r_alu_result;
    assign io_ex.o_write_data  = r_write_data;
    assign io_ex.o_imm_ext     = r_imm_ext;
    assign io_ex.o_rd_addr     = r_rd_addr;
    assign io_ex.o_result_src  = r_result_src;
    assign io_ex.o_mem_we      = r_mem_we;
    assign io_ex.o_reg_we      = r_reg_we;
    assign io_ex.o_func3       = r_func3_q;
    assign io_ex.o_forward_src = r_forward_src;
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage (ALU, MUL/DIV, stall, flush, reset).
module tb_execute_stage;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int RW = 5;

    logic i_clk;
    logic i_arst;
    int   n_checks = 0;
    int   n_errors = 0;

    execute_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_ADDR_W(RW)) u_if ();

    execute_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_ADDR_W(RW)) u_dut (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .io_ex  (u_if)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        u_if.i_stall       = 1'b0;
        u_if.i_flush       = 1'b0;
        u_if.i_pc          = 64'd0;
        u_if.i_pc_plus4    = 64'd0;
        u_if.i_rs1_data    = 64'd0;
        u_if.i_rs2_data    = 64'd0;
        u_if.i_imm_ext     = 64'd0;
        u_if.i_alu_src     = 1'b0;
        u_if.i_alu_op      = 4'd0;
        u_if.i_md_start    = 1'b0;
        u_if.i_rd_addr     = 5'd0;
        u_if.i_result_src  = 3'd0;
        u_if.i_mem_we      = 1'b0;
        u_if.i_reg_we      = 1'b0;
        u_if.i_func3       = 3'd0;
        u_if.i_forward_src = 2'd0;
    endtask

    task automatic alu_case(input string tag, input logic [3:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] imm, input logic src,
                            input logic [63:0] exp);
        @(negedge i_clk);
        u_if.i_alu_op   = op;
        u_if.i_rs1_data = a;
        u_if.i_rs2_data = b;
        u_if.i_imm_ext  = imm;
        u_if.i_alu_src  = src;
        u_if.i_md_start = 1'b0;
        u_if.i_reg_we   = 1'b1;
        u_if.i_mem_we   = 1'b0;
        @(posedge i_clk);
        #1;
        check_eq(tag, u_if.o_alu_result, exp);
    endtask

    task automatic md_case(input string tag, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp);
        int   busy_n;
        logic bad;
        @(negedge i_clk);
        u_if.i_func3    = f3;
        u_if.i_rs1_data = a;
        u_if.i_rs2_data = b;
        u_if.i_alu_op   = 4'd0;
        u_if.i_md_start = 1'b1;
        u_if.i_reg_we   = 1'b1;
        u_if.i_mem_we   = 1'b0;
        busy_n = 0;
        bad    = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!u_if.o_busy) break;
            busy_n++;
            @(posedge i_clk);
            #1;
            bad = bad | u_if.o_reg_we | u_if.o_mem_we;
            @(negedge i_clk);
        end
        @(posedge i_clk);
        #1;
        u_if.i_md_start = 1'b0;
        check_eq({tag, " busy_cycles"}, 64'(busy_n), 64'd65);
        check_eq({tag, " bubble"}, {63'd0, bad}, 64'd0);
        check_eq(tag, u_if.o_alu_result, exp);
        check_eq({tag, " reg_we"}, {63'd0, u_if.o_reg_we}, 64'd1);
    endtask

    initial begin
        int busy_n;
        int cap;
        clear_inputs();
        i_arst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst alu_result", u_if.o_alu_result, 64'd0);
        check_eq("rst reg_we", {63'd0, u_if.o_reg_we}, 64'd0);
        check_eq("rst pc_target", u_if.o_pc_target, 64'd0);
        check_eq("rst busy", {63'd0, u_if.o_busy}, 64'd0);
        @(negedge i_clk);
        i_arst = 1'b0;

        // ADD with all pass-through fields
        @(negedge i_clk);
        u_if.i_pc          = 64'h1000;
        u_if.i_pc_plus4    = 64'h1004;
        u_if.i_rs1_data    = 64'd5;
        u_if.i_rs2_data    = 64'hFFFF_FFFF_FFFF_FFF9;
        u_if.i_imm_ext     = 64'hFFFF_FFFF_FFFF_FFF0;
        u_if.i_alu_src     = 1'b0;
        u_if.i_alu_op      = 4'd0;
        u_if.i_rd_addr     = 5'd7;
        u_if.i_result_src  = 3'd2;
        u_if.i_mem_we      = 1'b1;
        u_if.i_reg_we      = 1'b1;
        u_if.i_func3       = 3'd3;
        u_if.i_forward_src = 2'd1;
        #1;
        check_eq("add busy", {63'd0, u_if.o_busy}, 64'd0);
        @(posedge i_clk);
        #1;
        check_eq("add result", u_if.o_alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("add pc_target", u_if.o_pc_target, 64'h0FF0);
        check_eq("add write_data", u_if.o_write_data, 64'hFFFF_FFFF_FFFF_FFF9);
        check_eq("add imm_ext", u_if.o_imm_ext, 64'hFFFF_FFFF_FFFF_FFF0);
        check_eq("add pc_plus4", u_if.o_pc_plus4, 64'h1004);
        check_eq("add rd_addr", {59'd0, u_if.o_rd_addr}, 64'd7);
        check_eq("add result_src", {61'd0, u_if.o_result_src}, 64'd2);
        check_eq("add mem_we", {63'd0, u_if.o_mem_we}, 64'd1);
        check_eq("add func3", {61'd0, u_if.o_func3}, 64'd3);
        check_eq("add forward_src", {62'd0, u_if.o_forward_src}, 64'd1);

        // PC target wraps around the address space
        @(negedge i_clk);
        u_if.i_pc      = 64'hFFFF_FFFF_FFFF_FFFC;
        u_if.i_imm_ext = 64'd8;
        @(posedge i_clk);
        #1;
        check_eq("pc_target wrap", u_if.o_pc_target, 64'd4);

        alu_case("sub",       4'd1,  64'd10, 64'd3, 64'd0, 1'b0, 64'd7);
        alu_case("sub wrap",  4'd1,  64'd0,  64'd1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_case("add wrap",  4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1'b0, 64'd1);
        alu_case("and",       4'd2,  64'hF0F0, 64'hFF00, 64'd0, 1'b0, 64'hF000);
        alu_case("or",        4'd3,  64'hF0F0, 64'h0F0F, 64'd0, 1'b0, 64'hFFFF);
        alu_case("xor",       4'd4,  64'hFF00, 64'h0FF0, 64'd0, 1'b0, 64'hF0F0);
        alu_case("sll mask",  4'd5,  64'd1, 64'h43, 64'd0, 1'b0, 64'd8);
        alu_case("srl",       4'd6,  64'h8000_0000_0000_0000, 64'd63, 64'd0, 1'b0, 64'd1);
        alu_case("sra",       4'd7,  64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0, 64'hF800_0000_0000_0000);
        alu_case("slt",       4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd1);
        alu_case("sltu",      4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd0);
        alu_case("op12 zero", 4'd12, 64'd5, 64'd7, 64'd0, 1'b0, 64'd0);
        alu_case("add imm",   4'd0,  64'h20, 64'h999, 64'h10, 1'b1, 64'h30);

        md_case("div -20/3",   3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        md_case("rem -20/3",   3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        md_case("divu 7/0",    3'd5, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        md_case("remu 7/0",    3'd7, 64'd7, 64'd0, 64'd7);
        md_case("div -5/0",    3'd4, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        md_case("rem -5/0",    3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
        md_case("div ovf",     3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        md_case("rem ovf",     3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        md_case("mul -1*-1",   3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
`ifdef EXEC_MULH_EN
        md_case("mulhu max",   3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        md_case("mulh -1*-1",  3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        md_case("mulhsu -1*3", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        md_case("mulhu max",   3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
`endif

        // MUL 3*5 with a memory stall over cycles 60..70
        @(negedge i_clk);
        u_if.i_func3    = 3'd0;
        u_if.i_rs1_data = 64'd3;
        u_if.i_rs2_data = 64'd5;
        u_if.i_md_start = 1'b1;
        u_if.i_reg_we   = 1'b1;
        busy_n = 0;
        cap    = -1;
        for (int c = 0; c < 100; c++) begin
            u_if.i_stall = (c >= 60 && c <= 70);
            #1;
            if (u_if.o_busy) busy_n++;
            @(posedge i_clk);
            #1;
            if (u_if.o_reg_we) begin
                cap = c;
                break;
            end
            @(negedge i_clk);
        end
        u_if.i_md_start = 1'b0;
        u_if.i_stall    = 1'b0;
        check_eq("stall busy_cycles", 64'(busy_n), 64'd65);
        check_eq("stall capture_cycle", 64'(cap), 64'd71);
        check_eq("stall mul result", u_if.o_alu_result, 64'd15);

        // DIVU aborted by a flush at cycle 10
        @(negedge i_clk);
        u_if.i_func3    = 3'd5;
        u_if.i_rs1_data = 64'd100;
        u_if.i_rs2_data = 64'd7;
        u_if.i_md_start = 1'b1;
        repeat (10) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
        u_if.i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        u_if.i_flush    = 1'b0;
        u_if.i_md_start = 1'b0;
        #1;
        check_eq("flush busy", {63'd0, u_if.o_busy}, 64'd0);
        check_eq("flush reg_we", {63'd0, u_if.o_reg_we}, 64'd0);
        alu_case("add after flush", 4'd0, 64'd10, 64'd20, 64'd0, 1'b0, 64'd30);

        // A start arriving together with a flush is dropped
        @(negedge i_clk);
        u_if.i_func3    = 3'd0;
        u_if.i_md_start = 1'b1;
        u_if.i_flush    = 1'b1;
        #1;
        check_eq("flush start busy", {63'd0, u_if.o_busy}, 64'd0);
        @(posedge i_clk);
        #1;
        u_if.i_md_start = 1'b0;
        u_if.i_flush    = 1'b0;
        #1;
        check_eq("flush start dropped", {63'd0, u_if.o_busy}, 64'd0);

        // Reset in the middle of a stalled MUL clears held EX/MEM contents
        alu_case("add before rst", 4'd0, 64'h1200, 64'h34, 64'd0, 1'b0, 64'h1234);
        @(negedge i_clk);
        u_if.i_stall    = 1'b1;
        u_if.i_func3    = 3'd0;
        u_if.i_md_start = 1'b1;
        repeat (3) @(posedge i_clk);
        #2;
        check_eq("stall hold", u_if.o_alu_result, 64'h1234);
        i_arst          = 1'b1;
        u_if.i_md_start = 1'b0;
        u_if.i_stall    = 1'b0;
        #1;
        check_eq("midop rst result", u_if.o_alu_result, 64'd0);
        check_eq("midop rst reg_we", {63'd0, u_if.o_reg_we}, 64'd0);
        check_eq("midop rst busy", {63'd0, u_if.o_busy}, 64'd0);
        @(negedge i_clk);
        i_arst = 1'b0;
        md_case("mul after rst", 3'd0, 64'd3, 64'd5, 64'd15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
